reg_file: RTL and testbench

//   General-purpose register file for the 5-stage pipelined CPU: 16 x 16-bit registers,
//   two enabled read ports (decode stage) and one write port (writeback stage).
//   R0 is hardwired to zero. Read data is registered, so it appears one clock after the

---
 rtl/reg_file.sv | 88 ++++++++
 tb/tb_reg_file.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   General-purpose register file: 2**ADDR_W x DATA_W registers (16 x 16 by
//   default), two independently enabled registered read ports and one write
//   port. R0 is hardwired to zero: writes to it are dropped and reads of it
//   return 0.
//
//   Optional feature macro: REG_FILE_BYPASS_EN
//     defined   : a read at the same edge as a write to the same non-zero
//                 address captures the new write data.
//     undefined : a same-edge read captures the old register contents.
//
// Ports
//   clk       in   1        rising-edge clock
//   rst       in   1        synchronous active-high reset; clears registers,
//                           p0 and p2; overrides WE/re0/re1 in that cycle
//   WE        in   1        write enable
//   dst_addr  in   ADDR_W   write address
//   dst       in   DATA_W   write data
//   re0       in   1        read enable, port 0
//   p0_addr   in   ADDR_W   read address, port 0
//   p0        out  DATA_W   registered read data, port 0 (holds when re0=0)
//   re1       in   1        read enable, port 1
//   p1_addr   in   ADDR_W   read address, port 1
//   p2        out  DATA_W   registered read data, port 1 (holds when re1=0)
// -----------------------------------------------------------------------------
module reg_file #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              WE,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [DATA_W-1:0] dst,
   input  logic              re0,
   input  logic [ADDR_W-1:0] p0_addr,
   output logic [DATA_W-1:0] p0,
   input  logic              re1,
   input  logic [ADDR_W-1:0] p1_addr,
   output logic [DATA_W-1:0] p2
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [NREG];
   logic [DATA_W-1:0] rd0_val;
   logic [DATA_W-1:0] rd1_val;
   logic              wr_live;

   // A write only takes effect for a non-zero destination.
   assign wr_live = WE && (dst_addr != '0);

   // Read-data selection for each port, evaluated against pre-edge state.
   always_comb begin
      rd0_val = '0;
      rd1_val = '0;
      if (p0_addr != '0) begin
`ifdef REG_FILE_BYPASS_EN
         if (wr_live && (dst_addr == p0_addr)) rd0_val = dst;
         else                                  rd0_val = mem[p0_addr];
`else
         rd0_val = mem[p0_addr];
`endif
      end
      if (p1_addr != '0) begin
`ifdef REG_FILE_BYPASS_EN
         if (wr_live && (dst_addr == p1_addr)) rd1_val = dst;
         else                                  rd1_val = mem[p1_addr];
`else
         rd1_val = mem[p1_addr];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
         p0 <= '0;
         p2 <= '0;
      end else begin
         if (wr_live) mem[dst_addr] <= dst;
         if (re0)     p0 <= rd0_val;
         if (re1)     p2 <= rd1_val;
      end
   end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        WE;
   logic [3:0]  dst_addr;
   logic [15:0] dst;
   logic        re0;
   logic [3:0]  p0_addr;
   logic [15:0] p0;
   logic        re1;
   logic [3:0]  p1_addr;
   logic [15:0] p2;

`ifdef REG_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   // Scoreboard: expected p0 then p2, pushed when a step is driven.
   logic [15:0] exp_q[$];

   // Reference model state.
   logic [15:0] mdl [16];
   logic [15:0] m_p0;
   logic [15:0] m_p2;

   reg_file dut (
      .clk      (clk),
      .rst      (rst),
      .WE       (WE),
      .dst_addr (dst_addr),
      .dst      (dst),
      .re0      (re0),
      .p0_addr  (p0_addr),
      .p0       (p0),
      .re1      (re1),
      .p1_addr  (p1_addr),
      .p2       (p2)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mval(input logic [3:0] a, input logic we,
                                        input logic [3:0] da, input logic [15:0] d);
      if (a == 4'd0) return 16'h0000;
      if (BYP && we && (da == a)) return d;
      return mdl[a];
   endfunction

   task automatic check(input string tag, input logic [15:0] obs);
      logic [15:0] e;
      e = exp_q.pop_front();
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask

   // One clock of stimulus: drive at negedge, predict, sample #1 after posedge.
   task automatic step(input string tag, input logic r, input logic we,
                       input logic [3:0] da, input logic [15:0] d,
                       input logic e0, input logic [3:0] a0,
                       input logic e1, input logic [3:0] a1);
      @(negedge clk);
      rst = r; WE = we; dst_addr = da; dst = d;
      re0 = e0; p0_addr = a0; re1 = e1; p1_addr = a1;
      if (r) begin
         m_p0 = 16'h0; m_p2 = 16'h0;
      end else begin
         if (e0) m_p0 = mval(a0, we, da, d);
         if (e1) m_p2 = mval(a1, we, da, d);
      end
      exp_q.push_back(m_p0);
      exp_q.push_back(m_p2);
      @(posedge clk);
      if (r) begin
         for (int k = 0; k < 16; k++) mdl[k] = 16'h0;
      end else if (we && da != 4'd0) begin
         mdl[da] = d;
      end
      #1;
      check({tag, ".p0"}, p0);
      check({tag, ".p2"}, p2);
   endtask

   initial begin
      logic [15:0] rv;
      rst = 1'b0; WE = 1'b0; dst_addr = '0; dst = '0;
      re0 = 1'b0; p0_addr = '0; re1 = 1'b0; p1_addr = '0;
      for (int k = 0; k < 16; k++) mdl[k] = 16'h0;
      m_p0 = 16'h0; m_p2 = 16'h0;

      // 1: reset, then every register reads zero
      step("reset", 1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0);
      for (int i = 0; i < 16; i++)
         step("rst_read", 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'(i), 1'b1, 4'(15 - i));

      // 2: write i+1 to every address, read back (R0 stays 0)
      for (int i = 0; i < 16; i++)
         step("wr_all", 1'b0, 1'b1, 4'(i), 16'(i + 1), 1'b0, 4'd0, 1'b0, 4'd0);
      for (int i = 0; i < 16; i++)
         step("rd_all", 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'(i), 1'b1, 4'(15 - i));
      // explicit spot checks of R5 and R15
      step("r5_r15", 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 1'b1, 4'd15);
      checks++;
      assert (p0 === 16'h0006 && p2 === 16'h0010) else begin
         errors++;
         $error("FAIL r5_r15_const observed=%h/%h expected=0006/0010", p0, p2);
      end

      // 3: disabled reads hold, then port 1 alone updates
      for (int i = 0; i < 16; i++)
         step("hold", 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'(i), 1'b0, 4'(i));
      for (int i = 1; i < 16; i += 3)
         step("re1_only", 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'(i), 1'b1, 4'(i));

      // 4: same-edge write/read of R3
      step("same_edge", 1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b1, 4'd3, 1'b0, 4'd0);
      checks++;
      assert (p0 === (BYP ? 16'hBEEF : 16'h0004)) else begin
         errors++;
         $error("FAIL same_edge_const observed=%h expected=%h", p0, BYP ? 16'hBEEF : 16'h0004);
      end
      step("after_wr", 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 1'b1, 4'd3);

      // 5: R0 write ignored; both ports on the same address
      step("r0_write", 1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 1'b0, 4'd0);
      step("r0_read", 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 1'b1, 4'd0);
      step("same_addr", 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 1'b1, 4'd7);
      step("r0_bypass", 1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 1'b1, 4'd0);

      // 6: reset with a pending write discards it
      step("pre_rst_wr", 1'b0, 1'b1, 4'd9, 16'h5555, 1'b0, 4'd0, 1'b0, 4'd0);
      step("rst_wr", 1'b1, 1'b1, 4'd9, 16'h1234, 1'b1, 4'd9, 1'b1, 4'd9);
      for (int i = 0; i < 16; i++)
         step("post_rst", 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'(i), 1'b1, 4'(i));

      // random mixed traffic
      for (int n = 0; n < 60; n++) begin
         rv = 16'($urandom_range(0, 16'hFFFF));
         step("rand", 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rv,
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
